// File: rtl/root_div_pkg.sv
// Shared constants, FSM state encoding and operand bundle for the
// fixed-point root divider.
package root_div_pkg;

    localparam int DW   = 20;
    localparam int FRAC = 10;
    localparam int ITER = DW + FRAC;
    localparam int CW   = $clog2(ITER);

    localparam logic [DW-1:0] SAT_VAL = '1;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        OUT
    } state_t;

    typedef struct packed {
        logic [DW-1:0] root;
        logic [DW-1:0] divisor;
    } operands_t;

endpackage

// File: rtl/root_fx_divider_if.sv
// Operand/result bundle between the root stage, the divider and its consumer.
interface root_fx_divider_if;
    import root_div_pkg::*;

    logic          in_valid;
    logic [DW-1:0] in_root;
    logic [DW-1:0] in_divisor;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_dbz;
    logic          out_sat;
    logic          busy;
    logic          ovf_err;

    modport master (
        output in_valid, in_root, in_divisor,
        input  out_valid, out_data, out_dbz, out_sat, busy, ovf_err
    );

    modport slave (
        input  in_valid, in_root, in_divisor,
        output out_valid, out_data, out_dbz, out_sat, busy, ovf_err
    );

endinterface

// File: rtl/fx_div_step.sv
// One restoring-division step: shift in the next dividend bit and subtract
// the divisor when it fits.
module fx_div_step
    import root_div_pkg::*;
(
    input  logic [DW:0]   rem_in,
    input  logic          dvd_bit,
    input  logic [DW-1:0] divisor,
    output logic [DW:0]   rem_out,
    output logic          q_bit
);

    logic [DW:0] shifted;
    logic [DW:0] diff;
    logic        unused_rem_msb;

    // The remainder always stays below the divisor, so its MSB is zero here.
    assign unused_rem_msb = rem_in[DW];

    assign shifted = {rem_in[DW-1:0], dvd_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/root_fx_divider.sv
// UQ10.10 restoring divider behind the root stage, with a one-deep skid
// register for operand pulses that arrive while a division is running.
module root_fx_divider
    import root_div_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    root_fx_divider_if.slave  bus
);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [DW:0]      rem_q;
    logic [ITER-1:0]  dq_q;      // dividend bits shift out the top, quotient bits in the bottom
    logic [DW-1:0]    dvs_q;
    logic             pend_v_q;
    operands_t        pend_q;
    logic             out_valid_q, out_dbz_q, out_sat_q, ovf_q;
    logic [DW-1:0]    out_data_q;

    logic [DW:0]      rem_nx;
    logic             q_bit;
    logic [ITER-1:0]  q_final;
    operands_t        in_ops, src_ops;
    logic             load_in, load_pend, cap_pend, drop, finish;
    logic [DW-1:0]    res_data;
    logic             res_dbz, res_sat;

    fx_div_step u_step (
        .rem_in  (rem_q),
        .dvd_bit (dq_q[ITER-1]),
        .divisor (dvs_q),
        .rem_out (rem_nx),
        .q_bit   (q_bit)
    );

    assign q_final = {dq_q[ITER-2:0], q_bit};
    assign in_ops  = '{root: bus.in_root, divisor: bus.in_divisor};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        state_d   = state_q;
        load_in   = 1'b0;
        load_pend = 1'b0;
        cap_pend  = 1'b0;
        drop      = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    load_in = 1'b1;
                    state_d = DIV;
                end
            end
            DIV: begin
                if (cnt_q == CW'(ITER - 1)) begin
                    finish  = 1'b1;
                    state_d = OUT;
                end
                if (bus.in_valid) begin
                    cap_pend = !pend_v_q;
                    drop     = pend_v_q;
                end
            end
            OUT: begin
                if (pend_v_q) begin
                    load_pend = 1'b1;
                    cap_pend  = bus.in_valid;
                    state_d   = DIV;
                end else if (bus.in_valid) begin
                    load_in = 1'b1;
                    state_d = DIV;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        src_ops  = load_pend ? pend_q : in_ops;
        res_data = q_final[DW-1:0];
        res_dbz  = 1'b0;
        res_sat  = 1'b0;
        // A zero divisor also yields an all-ones quotient, so it must win over saturation.
        if (dvs_q == '0) begin
            res_data = SAT_VAL;
            res_dbz  = 1'b1;
        end else if (|q_final[ITER-1:DW]) begin
            res_data = SAT_VAL;
            res_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dq_q        <= '0;
            dvs_q       <= '0;
            pend_v_q    <= 1'b0;
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_dbz_q   <= 1'b0;
            out_sat_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= finish;

            if (load_in || load_pend) begin
                cnt_q <= '0;
                rem_q <= '0;
                dq_q  <= {src_ops.root, {FRAC{1'b0}}};
                dvs_q <= src_ops.divisor;
            end else if (state_q == DIV) begin
                cnt_q <= cnt_q + CW'(1);
                rem_q <= rem_nx;
                dq_q  <= q_final;
            end

            if (cap_pend) begin
                pend_v_q <= 1'b1;
                pend_q   <= in_ops;
            end else if (load_pend) begin
                pend_v_q <= 1'b0;
            end

            if (drop) begin
                ovf_q <= 1'b1;
            end

            if (finish) begin
                out_data_q <= res_data;
                out_dbz_q  <= res_dbz;
                out_sat_q  <= res_sat;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_dbz   = out_dbz_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.ovf_err   = ovf_q;

endmodule
